onehot_queue_ctrl: RTL and testbench

Pointer and occupancy controller for a circular queue built on the one-hot-addressed, no-decode static RAM.
- Keeps one-hot head and tail pointers, so the RAM needs no address decoder.
- Drives the RAM's single write port (one-hot address + enable) and one read port (one-hot address).
- Provides a valid/ready enqueue/dequeue handshake plus full/empty/almost-full status.
- Used for in-order structures such as free lists and issue/load-store queue storage.

---
 rtl/onehot_queue_ctrl_if.sv | 33 +++
 rtl/onehot_queue_ctrl.sv | 99 +++++++++
 tb/tb_onehot_queue_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_queue_ctrl_if.sv
// Enqueue/dequeue handshake and RAM port bundle for onehot_queue_ctrl.
// The controller uses the slave view. The producer, consumer and RAM side use the master view.
interface onehot_queue_ctrl_if #(
  parameter int DEPTH = 16
);
  logic             enqValid_i;
  logic             enqReady_o;
  logic             deqValid_o;
  logic             deqReady_i;
  logic             wrEn_o;
  logic [DEPTH-1:0] wrAddr_o;
  logic [DEPTH-1:0] rdAddr_o;

  modport slave (
    input  enqValid_i,
    input  deqReady_i,
    output enqReady_o,
    output deqValid_o,
    output wrEn_o,
    output wrAddr_o,
    output rdAddr_o
  );

  modport master (
    output enqValid_i,
    output deqReady_i,
    input  enqReady_o,
    input  deqValid_o,
    input  wrEn_o,
    input  wrAddr_o,
    input  rdAddr_o
  );
endinterface

// File: rtl/onehot_queue_ctrl.sv
// Head/tail/occupancy controller for a circular queue on a one-hot addressed RAM.
// One-hot pointers drive the RAM word lines directly, so the RAM needs no address decoder.
module onehot_queue_ctrl #(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1),
  parameter int AF_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ramReady_i,
  input  logic                  flush_i,
  onehot_queue_ctrl_if.slave    q_if,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almostFull_o,
  output logic                  ptrErr_o
);

  localparam logic [DEPTH-1:0]     PTR_RST   = DEPTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_THRESH = CNT_WIDTH'(DEPTH - AF_MARGIN);

  logic [DEPTH-1:0]     head_q, head_d;
  logic [DEPTH-1:0]     tail_q, tail_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ptrErr_q, ptrErr_d;

  logic full, empty;
  logic enq_rdy, deq_vld;
  logic enq, deq;

  function automatic logic [DEPTH-1:0] rotl1(input logic [DEPTH-1:0] p);
    return {p[DEPTH-2:0], p[DEPTH-1]};
  endfunction

  function automatic logic is_onehot(input logic [DEPTH-1:0] p);
    int unsigned n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      n += {31'd0, p[i]};
    end
    return (n == 1);
  endfunction

  // Status derives only from the registered count.
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // No full bypass and no write-through: a same-cycle dequeue cannot open a
  // slot for an enqueue, and a same-cycle enqueue cannot feed a dequeue.
  assign enq_rdy = ramReady_i & ~full  & ~flush_i;
  assign deq_vld = ramReady_i & ~empty & ~flush_i;
  assign enq     = q_if.enqValid_i & enq_rdy;
  assign deq     = deq_vld & q_if.deqReady_i;

  assign q_if.enqReady_o = enq_rdy;
  assign q_if.deqValid_o = deq_vld;
  assign q_if.wrEn_o     = enq;
  assign q_if.wrAddr_o   = tail_q;
  assign q_if.rdAddr_o   = head_q;

  assign count_o      = count_q;
  assign full_o       = full;
  assign empty_o      = empty;
  assign almostFull_o = (count_q >= AF_THRESH);
  assign ptrErr_o     = ptrErr_q;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    ptrErr_d = ptrErr_q | ~is_onehot(head_q) | ~is_onehot(tail_q);
    if (flush_i) begin
      head_d  = PTR_RST;
      tail_d  = PTR_RST;
      count_d = '0;
    end else begin
      if (enq) tail_d = rotl1(tail_q);
      if (deq) head_d = rotl1(head_q);
      count_d = count_q + CNT_WIDTH'(enq) - CNT_WIDTH'(deq);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= PTR_RST;
      tail_q   <= PTR_RST;
      count_q  <= '0;
      ptrErr_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ptrErr_q <= ptrErr_d;
    end
  end

endmodule

// File: tb/tb_onehot_queue_ctrl.sv
// Bench for onehot_queue_ctrl: directed scenarios plus random traffic against an index/queue model,
// with a small one-hot addressed RAM so that dequeued data can be compared with what was enqueued.
module tb_onehot_queue_ctrl;
  localparam int DEPTH     = 16;
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam int AF_MARGIN = 2;

  logic clk = 1'b0;
  logic reset, ramReady, flush;
  logic [CNT_WIDTH-1:0] count;
  logic full, empty, almostFull, ptrErr;
  logic [7:0] wdata;
  logic [7:0] ram [DEPTH];
  logic [7:0] rdata;

  onehot_queue_ctrl_if #(.DEPTH(DEPTH)) qif ();

  onehot_queue_ctrl #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk(clk), .reset(reset), .ramReady_i(ramReady), .flush_i(flush), .q_if(qif.slave),
    .count_o(count), .full_o(full), .empty_o(empty), .almostFull_o(almostFull), .ptrErr_o(ptrErr)
  );

  always #5 clk = ~clk;

  function automatic int oh2idx(input logic [DEPTH-1:0] p);
    for (int i = 0; i < DEPTH; i++) if (p[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) if (qif.wrEn_o) ram[oh2idx(qif.wrAddr_o)] <= wdata;
  always_comb rdata = ram[oh2idx(qif.rdAddr_o)];

  // Reference model: plain indices, an occupancy integer and a data queue.
  int m_head, m_tail, m_cnt;
  logic [7:0] m_q[$];
  bit e_erdy, e_dvld, e_enq, e_deq;
  logic [7:0] e_rdata;
  int pass_cnt = 0, total_cnt = 0;

  task automatic model_reset();
    m_head = 0; m_tail = 0; m_cnt = 0; m_q.delete();
  endtask

  task automatic drive(input bit ev, input bit dr, input bit fl, input bit rr);
    qif.enqValid_i = ev; qif.deqReady_i = dr; flush = fl; ramReady = rr;
    wdata = 8'($urandom);
    #1;
    e_erdy  = rr && !fl && (m_cnt < DEPTH);
    e_dvld  = rr && !fl && (m_cnt > 0);
    e_enq   = ev && e_erdy;
    e_deq   = dr && e_dvld;
    e_rdata = (m_q.size() > 0) ? m_q[0] : 8'h00;
  endtask

  task automatic advance();
    @(posedge clk);
    if (flush) model_reset();
    else begin
      if (e_enq) begin m_q.push_back(wdata); m_tail = (m_tail + 1) % DEPTH; m_cnt++; end
      if (e_deq) begin void'(m_q.pop_front()); m_head = (m_head + 1) % DEPTH; m_cnt--; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; ramReady = 1'b0; flush = 1'b0;
    qif.enqValid_i = 1'b0; qif.deqReady_i = 1'b0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({qif.enqReady_o, qif.deqValid_o, qif.wrEn_o, empty, full, almostFull, ptrErr} !== 7'b0001000)
      $display("FAIL reset_flags got %b want 0001000",
               {qif.enqReady_o, qif.deqValid_o, qif.wrEn_o, empty, full, almostFull, ptrErr});
    else pass_cnt++;
    total_cnt++;
    if ({count, qif.rdAddr_o, qif.wrAddr_o} !== {CNT_WIDTH'(0), 16'h0001, 16'h0001})
      $display("FAIL reset_state got cnt=%0d rd=%h wr=%h want 0/0001/0001", count, qif.rdAddr_o, qif.wrAddr_o);
    else pass_cnt++;
    reset = 1'b0;
    drive(0, 0, 0, 1);
    total_cnt++;
    if (qif.enqReady_o !== 1'b1) $display("FAIL reset_enq_ready got %b want 1", qif.enqReady_o);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 1);
      total_cnt++;
      if ({qif.wrEn_o, qif.wrAddr_o} !== {1'b1, DEPTH'(1) << i})
        $display("FAIL fill_wr[%0d] got en=%b addr=%h want 1/%h", i, qif.wrEn_o, qif.wrAddr_o, DEPTH'(1) << i);
      else pass_cnt++;
      advance();
      total_cnt++;
      if ({count, almostFull} !== {CNT_WIDTH'(i + 1), (i + 1 >= DEPTH - AF_MARGIN)})
        $display("FAIL fill_cnt[%0d] got cnt=%0d af=%b want %0d/%b", i, count, almostFull, i + 1,
                 (i + 1 >= DEPTH - AF_MARGIN));
      else pass_cnt++;
    end
    drive(1, 0, 0, 1);
    total_cnt++;
    if ({full, qif.enqReady_o, qif.wrEn_o, qif.wrAddr_o} !== {3'b100, 16'h0001})
      $display("FAIL full_state got full=%b rdy=%b en=%b wr=%h want 1/0/0/0001", full, qif.enqReady_o,
               qif.wrEn_o, qif.wrAddr_o);
    else pass_cnt++;
  endtask

  task automatic test_full_deq();
    drive(1, 1, 0, 1);
    total_cnt++;
    if ({qif.enqReady_o, qif.wrEn_o, qif.deqValid_o, rdata} !== {3'b001, e_rdata})
      $display("FAIL full_deq_hs got rdy=%b en=%b vld=%b data=%h want 0/0/1/%h", qif.enqReady_o, qif.wrEn_o,
               qif.deqValid_o, rdata, e_rdata);
    else pass_cnt++;
    advance();
    total_cnt++;
    if ({count, qif.rdAddr_o} !== {CNT_WIDTH'(15), 16'h0002})
      $display("FAIL full_deq_state got cnt=%0d rd=%h want 15/0002", count, qif.rdAddr_o);
    else pass_cnt++;
    while (m_cnt > 0) begin
      drive(0, 1, 0, 1);
      total_cnt++;
      if (rdata !== e_rdata) $display("FAIL drain_data got %h want %h", rdata, e_rdata);
      else pass_cnt++;
      advance();
    end
  endtask

  task automatic test_empty_enq_deq();
    drive(1, 1, 0, 1);
    total_cnt++;
    if ({empty, qif.deqValid_o, qif.wrEn_o} !== 3'b101)
      $display("FAIL empty_bypass got empty=%b vld=%b en=%b want 1/0/1", empty, qif.deqValid_o, qif.wrEn_o);
    else pass_cnt++;
    advance();
    total_cnt++;
    if (count !== CNT_WIDTH'(1)) $display("FAIL empty_cnt got %0d want 1", count);
    else pass_cnt++;
    drive(0, 1, 0, 1);
    total_cnt++;
    if ({qif.deqValid_o, rdata} !== {1'b1, e_rdata})
      $display("FAIL empty_readback got vld=%b data=%h want 1/%h", qif.deqValid_o, rdata, e_rdata);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_wrap();
    reset = 1'b1; #1; reset = 1'b0; model_reset();
    @(negedge clk);
    repeat (7) begin drive(1, 0, 0, 1); advance(); end
    repeat (7) begin drive(0, 1, 0, 1); advance(); end
    repeat (5) begin drive(1, 0, 0, 1); advance(); end
    total_cnt++;
    if ({count, qif.rdAddr_o} !== {CNT_WIDTH'(5), 16'h0080})
      $display("FAIL wrap_setup got cnt=%0d rd=%h want 5/0080", count, qif.rdAddr_o);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 1);
      total_cnt++;
      if ({qif.wrEn_o, qif.deqValid_o, rdata} !== {2'b11, e_rdata})
        $display("FAIL wrap_hs[%0d] got en=%b vld=%b data=%h want 1/1/%h", i, qif.wrEn_o, qif.deqValid_o,
                 rdata, e_rdata);
      else pass_cnt++;
      advance();
      total_cnt++;
      if ({count, qif.rdAddr_o, qif.wrAddr_o} !== {CNT_WIDTH'(5), DEPTH'(1) << m_head, DEPTH'(1) << m_tail})
        $display("FAIL wrap_ptr[%0d] got cnt=%0d rd=%h wr=%h want 5/%h/%h", i, count, qif.rdAddr_o,
                 qif.wrAddr_o, DEPTH'(1) << m_head, DEPTH'(1) << m_tail);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    while (m_cnt < 9) begin drive(1, 0, 0, 1); advance(); end
    drive(1, 1, 1, 1);
    total_cnt++;
    if ({qif.wrEn_o, qif.enqReady_o, qif.deqValid_o, count} !== {3'b000, CNT_WIDTH'(9)})
      $display("FAIL flush_mask got en=%b rdy=%b vld=%b cnt=%0d want 0/0/0/9", qif.wrEn_o, qif.enqReady_o,
               qif.deqValid_o, count);
    else pass_cnt++;
    advance();
    total_cnt++;
    if ({count, empty, qif.rdAddr_o, qif.wrAddr_o} !== {CNT_WIDTH'(0), 1'b1, 16'h0001, 16'h0001})
      $display("FAIL flush_state got cnt=%0d empty=%b rd=%h wr=%h want 0/1/0001/0001", count, empty,
               qif.rdAddr_o, qif.wrAddr_o);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 7) != 0);
      total_cnt++;
      if ({qif.enqReady_o, qif.deqValid_o, qif.wrEn_o} !== {e_erdy, e_dvld, e_enq})
        $display("FAIL rnd_hs[%0d] got %b want %b", i, {qif.enqReady_o, qif.deqValid_o, qif.wrEn_o},
                 {e_erdy, e_dvld, e_enq});
      else pass_cnt++;
      total_cnt++;
      if ({count, full, empty, almostFull, ptrErr, qif.rdAddr_o, qif.wrAddr_o} !==
          {CNT_WIDTH'(m_cnt), m_cnt == DEPTH, m_cnt == 0, m_cnt >= DEPTH - AF_MARGIN, 1'b0,
           DEPTH'(1) << m_head, DEPTH'(1) << m_tail})
        $display("FAIL rnd_state[%0d] got cnt=%0d f=%b e=%b af=%b err=%b rd=%h wr=%h want cnt=%0d", i, count,
                 full, empty, almostFull, ptrErr, qif.rdAddr_o, qif.wrAddr_o, m_cnt);
      else pass_cnt++;
      if (e_deq) begin
        total_cnt++;
        if (rdata !== e_rdata) $display("FAIL rnd_data[%0d] got %h want %h", i, rdata, e_rdata);
        else pass_cnt++;
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    while (m_cnt < 6) begin drive(1, 0, 0, 1); advance(); end
    drive(1, 1, 0, 1);
    reset = 1'b1; ramReady = 1'b0;
    #1;
    model_reset();
    total_cnt++;
    if ({count, empty, ptrErr, qif.wrEn_o, qif.rdAddr_o, qif.wrAddr_o} !==
        {CNT_WIDTH'(0), 3'b100, 16'h0001, 16'h0001})
      $display("FAIL async_reset got cnt=%0d empty=%b err=%b en=%b rd=%h wr=%h want 0/1/0/0/0001/0001", count,
               empty, ptrErr, qif.wrEn_o, qif.rdAddr_o, qif.wrAddr_o);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_deq();
    test_empty_enq_deq();
    test_wrap();
    test_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
